// File: rtl/sqrt_frac_rem.sv
// sqrt_frac_rem
//   Multicycle restoring square root of an unsigned radicand. The result
//   has FRAC fractional bits and comes with the exact remainder. The
//   engine produces one root bit per clock. The result can optionally be
//   rounded to nearest.
//
//   Parameters
//     WIDTH  radicand width (even, >= 4)
//     FRAC   fractional result bits (0..WIDTH/2)
//     ROUND  1 = round root to nearest, 0 = truncate
//
//   Ports
//     clk    rising-edge clock
//     rst    asynchronous active-low reset
//     start  operation request, sampled only while busy is low
//     abort  synchronous cancel of an operation in flight
//     num    radicand, captured on the accepting edge
//     busy   high while an operation is in flight
//     done   one-cycle pulse when out/rem are updated
//     out    root (RW = WIDTH/2 + FRAC bits)
//     rem    num*4^FRAC - floor_root^2 (always the pre-rounding remainder)
module sqrt_frac_rem #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 0,
  parameter int ROUND = 0,
  localparam int RW   = WIDTH/2 + FRAC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] num,
  output logic             busy,
  output logic             done,
  output logic [RW-1:0]    out,
  output logic [RW:0]      rem
);

  localparam int RADW = 2*RW;
  localparam int CW   = (RW > 1) ? $clog2(RW) : 1;

  generate
    if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
      $error("sqrt_frac_rem: WIDTH must be even and at least 4");
    end
    if (FRAC < 0 || FRAC > WIDTH/2) begin : g_bad_frac
      $error("sqrt_frac_rem: FRAC must lie in 0..WIDTH/2");
    end
  endgenerate

  // FIN is the settle cycle after the last digit. It lets out/rem load
  // from registered values, and RND adds the optional rounding cycle.
  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_FIN,
    S_RND,
    S_DONE
  } state_t;

  state_t state, state_next;

  logic [RADW-1:0] rad;
  logic [RW-1:0]   root;
  logic [RW+1:0]   acc;
  logic [CW-1:0]   cnt;

  logic            accept;
  logic [1:0]      bits;
  logic [RW+1:0]   shifted;
  logic [RW+1:0]   trial;
  logic            take;
  logic [RW-1:0]   rounded;

  assign accept = (state == S_IDLE || state == S_DONE) && start && !abort;

  // One restoring step. The compare is done at full width so that the
  // sign of the trial is exact. When the trial is taken, the new
  // remainder is at most 2*root, so it fits the truncated width.
  always_comb begin
    bits    = rad[RADW-1 -: 2];
    shifted = {acc[RW-1:0], bits};
    take    = ({acc, bits} >= {2'b00, root, 2'b01});
    trial   = shifted - {root, 2'b01};
    // Rounding up is needed when rem > root. Ties are impossible
    // because rem and root are integers.
    rounded = (({2'b00, root} < acc) && !(&root)) ? root + RW'(1) : root;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) state_next = S_CALC;
      end
      S_CALC: begin
        busy = 1'b1;
        if (abort)               state_next = S_IDLE;
        else if (cnt == '0)      state_next = S_FIN;
      end
      S_FIN: begin
        busy = 1'b1;
        if (abort)               state_next = S_IDLE;
        else if (ROUND != 0)     state_next = S_RND;
        else                     state_next = S_DONE;
      end
      S_RND: begin
        busy = 1'b1;
        state_next = abort ? S_IDLE : S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        state_next = accept ? S_CALC : S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath. The radicand is pre-scaled by 4^FRAC so that the fractional
  // digits fall out of the same integer iteration. The visible outputs
  // change only on the edge that enters DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rad  <= '0;
      root <= '0;
      acc  <= '0;
      cnt  <= '0;
      out  <= '0;
      rem  <= '0;
    end else begin
      if (accept) begin
        rad  <= RADW'(num) << (2*FRAC);
        root <= '0;
        acc  <= '0;
        cnt  <= CW'(RW-1);
      end else if (state == S_CALC) begin
        rad  <= rad << 2;
        acc  <= take ? trial : shifted;
        root <= {root[RW-2:0], take};
        cnt  <= cnt - CW'(1);
      end
      if (state_next == S_DONE) begin
        out <= (ROUND != 0) ? rounded : root;
        rem <= acc[RW:0];
      end
    end
  end

endmodule
